// File: rtl/urna_keypad_front.sv
`default_nettype none
// ============================================================================
// Module   : urna_keypad_front
// Brief    : Ballot-box operator front-end: synchronizes and debounces the
//            board keys and turns them into Digit/Valid/Next/Finish pulses.
//            Optional macro URNA_DEBOUNCE_EN selects full debouncers; when it
//            is undefined each key uses a plain falling-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module urna_keypad_front #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_DIGITS      = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [3:0]  DigitSw,
    input  logic        KeyConfirm_n,
    input  logic        KeyNext_n,
    input  logic        KeyFinish_n,
    output logic [3:0]  Digit,
    output logic        Valid,
    output logic        Next,
    output logic        Finish,
    output logic [2:0]  Count,
    output logic [15:0] Echo,
    output logic        Full
);

    localparam logic [2:0] c_MAX = 3'(MAX_DIGITS);

    // Key vector order: [0] confirm, [1] next, [2] finish; all active-low.
    logic [2:0]  r_key_s1;
    logic [2:0]  r_key_s2;
    logic [3:0]  r_sw_s1;
    logic [3:0]  r_sw_s2;
    logic [2:0]  w_evt;

    logic [3:0]  r_digit;
    logic        r_valid;
    logic        r_next;
    logic        r_finish;
    logic [2:0]  r_count;
    logic [15:0] r_echo;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_key_s1 <= 3'b111;
            r_key_s2 <= 3'b111;
            r_sw_s1  <= 4'd0;
            r_sw_s2  <= 4'd0;
        end else begin
            r_key_s1 <= {KeyFinish_n, KeyNext_n, KeyConfirm_n};
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= DigitSw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
`ifdef URNA_DEBOUNCE_EN
            localparam int              c_CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

            localparam logic [1:0] c_RELEASED    = 2'd0;
            localparam logic [1:0] c_PRESS_CHK   = 2'd1;
            localparam logic [1:0] c_PRESSED     = 2'd2;
            localparam logic [1:0] c_RELEASE_CHK = 2'd3;

            logic [1:0]      r_state;
            logic [c_CW-1:0] r_cnt;
            logic            w_lvl;

            assign w_lvl      = r_key_s2[gi];
            assign w_evt[gi]  = (r_state == c_PRESS_CHK) && !w_lvl && (r_cnt == c_CNT_LAST);

            // Counter stops at its last value, so it never wraps.
            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    r_state <= c_RELEASED;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        c_RELEASED: begin
                            if (!w_lvl) begin
                                r_state <= c_PRESS_CHK;
                                r_cnt   <= '0;
                            end
                        end
                        c_PRESS_CHK: begin
                            if (w_lvl)
                                r_state <= c_RELEASED;
                            else if (r_cnt == c_CNT_LAST)
                                r_state <= c_PRESSED;
                            else
                                r_cnt <= r_cnt + 1'b1;
                        end
                        c_PRESSED: begin
                            if (w_lvl) begin
                                r_state <= c_RELEASE_CHK;
                                r_cnt   <= '0;
                            end
                        end
                        c_RELEASE_CHK: begin
                            if (!w_lvl)
                                r_state <= c_PRESSED;
                            else if (r_cnt == c_CNT_LAST)
                                r_state <= c_RELEASED;
                            else
                                r_cnt <= r_cnt + 1'b1;
                        end
                        default: r_state <= c_RELEASED;
                    endcase
                end
            end
`else
            logic r_prev;

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn)
                    r_prev <= 1'b1;
                else
                    r_prev <= r_key_s2[gi];
            end

            assign w_evt[gi] = r_prev & ~r_key_s2[gi];
`endif
        end
    endgenerate

    // Finish outranks Next, which outranks Confirm; lower-priority events are dropped.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_digit  <= 4'd0;
            r_valid  <= 1'b0;
            r_next   <= 1'b0;
            r_finish <= 1'b0;
            r_count  <= 3'd0;
            r_echo   <= 16'd0;
        end else begin
            r_valid  <= 1'b0;
            r_next   <= 1'b0;
            r_finish <= 1'b0;
            if (w_evt[2]) begin
                r_finish <= 1'b1;
                r_count  <= 3'd0;
                r_echo   <= 16'd0;
            end else if (w_evt[1]) begin
                r_next  <= 1'b1;
                r_count <= 3'd0;
                r_echo  <= 16'd0;
            end else if (w_evt[0] && (r_count < c_MAX)) begin
                r_digit <= r_sw_s2;
                r_valid <= 1'b1;
                r_echo  <= {r_echo[11:0], r_sw_s2};
                r_count <= r_count + 3'd1;
            end
        end
    end

    assign Digit  = r_digit;
    assign Valid  = r_valid;
    assign Next   = r_next;
    assign Finish = r_finish;
    assign Count  = r_count;
    assign Echo   = r_echo;
    assign Full   = (r_count == c_MAX);

endmodule
`default_nettype wire
